ram_arbiter: RTL

- Shares the single data RAM port (16-bit address, 4-bit data) between two requesters.
- Requester 0 is the CPU core's RAM access; requester 1 is the host/debug loader port.
- Arbitration is round-robin, with an optional bounded lock that allows burst ownership.
- Each granted access issues exactly one RAM cycle; read data returns one cycle later with a valid strobe.

---
 rtl/ram_arbiter_pkg.sv | 13 +
 rtl/ram_arbiter_rr_pick2.sv | 11 +
 rtl/ram_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-requester RAM port arbiter.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam int CPU  = 0;
    localparam int HOST = 1;

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin pick; ptr names the requester favoured on a tie.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | ~ptr);
    assign gnt[1] = req[1] & (~req[0] | ptr);

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between CPU and host with round-robin and
// bounded burst locking; reads return one cycle after the grant.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 4,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [1:0]    lock,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

    state_t        state, state_n;
    logic          ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    rr_gnt, gnt_c;
    logic          own, oth, locked;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    rr_pick2 u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (rr_gnt)
    );

    always_comb begin
        gnt_c   = 2'b00;
        state_n = FREE;
        cnt_n   = '0;
        ptr_n   = ptr;
        own     = (state == LOCK1);
        oth     = ~own;
        locked  = (state != FREE) && req[own] && lock[own];
        if (locked) begin
            if (req[oth] && cnt == CMAX) begin
                // burst exhausted while the other side waits: forced yield
                gnt_c[oth] = 1'b1;
                ptr_n      = own;
            end else begin
                gnt_c[own] = 1'b1;
                state_n    = state;
                ptr_n      = oth;
                cnt_n      = (cnt == CMAX) ? cnt : cnt + 1'b1;
            end
        end else begin
            gnt_c = rr_gnt;
            if (rr_gnt != 2'b00) begin
                ptr_n = rr_gnt[CPU];
                if (rr_gnt[CPU] && lock[CPU]) begin
                    state_n = LOCK0;
                    cnt_n   = CW'(1);
                end else if (rr_gnt[HOST] && lock[HOST]) begin
                    state_n = LOCK1;
                    cnt_n   = CW'(1);
                end
            end
        end
    end

    // Grant must vanish the moment reset is asserted.
    assign gnt = rst ? gnt_c : 2'b00;

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (gnt[HOST]) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_we    = we[HOST];
            mem_re    = ~we[HOST];
        end else if (gnt[CPU]) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_we    = we[CPU];
            mem_re    = ~we[CPU];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FREE;
            ptr     <= 1'b0;
            cnt     <= '0;
            rvalid  <= 2'b00;
            rdata   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            rvalid  <= gnt & ~we;
            if ((gnt & ~we) != 2'b00) begin
                rdata <= mem_rdata;
            end
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
        end
    end

endmodule
